// File: rtl/dyn_adder_scheduler.sv
// dyn_adder_scheduler: round-robin front end that shares one 16-bit
// variable-latency adder among NUM_REQ requesters. One operation is in flight
// at a time; the settle latency is predicted from the operand propagate pairs.
// Optional macro DYN_ADD_WORST_CASE_EN forces every operation to MAX_LAT cycles.
module dyn_adder_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_LAT = 4,
    localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]       req_cin_i,
    output logic [WIDTH-1:0]         add_a_o,
    output logic [WIDTH-1:0]         add_b_o,
    output logic                     add_cin_o,
    output logic                     add_first_o,
    output logic                     add_request_o,
    input  logic [WIDTH-1:0]         add_sum_i,
    input  logic                     add_cout_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IdW-1:0]           rsp_id_o,
    output logic [WIDTH-1:0]         rsp_sum_o,
    output logic                     rsp_cout_o
);

    // Counter must hold the pair-derived maximum of 4 even if MAX_LAT is smaller.
    localparam int unsigned CntW = ($clog2(MAX_LAT + 1) > 3) ? $clog2(MAX_LAT + 1) : 3;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q;
    logic [IdW-1:0]     rr_q;
    logic [IdW-1:0]     id_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   add_a_q;
    logic [WIDTH-1:0]   add_b_q;
    logic               add_cin_q;
    logic               add_first_q;
    logic               add_request_q;
    logic               rsp_valid_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic               grant_vld;
    logic [IdW-1:0]     grant_idx;
    logic [IdW-1:0]     cand;
    logic [IdW-1:0]     rr_next;
    logic [WIDTH-1:0]   prop;
    logic [CntW-1:0]    lat;

    // Round-robin search from rr_q upward, wrapping modulo NUM_REQ.
    always_comb begin
        grant_vld   = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        req_ready_o = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = IdW'((int'(rr_q) + k) % int'(NUM_REQ));
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
        if (state_q == StIdle && !rst_i && grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        rr_next = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    // Settle-latency prediction from the latched operands.
    always_comb begin
        prop = add_a_q ^ add_b_q;
`ifdef DYN_ADD_WORST_CASE_EN
        lat = CntW'(MAX_LAT);
`else
        lat = CntW'(1) + CntW'(prop[3] & prop[4]) + CntW'(prop[7] & prop[8])
            + CntW'(prop[11] & prop[12]);
`endif
    end

    // Scheduler FSM with registered adder and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            rr_q          <= '0;
            id_q          <= '0;
            cnt_q         <= '0;
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_cin_q     <= 1'b0;
            add_first_q   <= 1'b0;
            add_request_q <= 1'b0;
            rsp_valid_q   <= 1'b0;
            sum_q         <= '0;
            cout_q        <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        add_a_q       <= req_a_i[grant_idx*WIDTH +: WIDTH];
                        add_b_q       <= req_b_i[grant_idx*WIDTH +: WIDTH];
                        add_cin_q     <= req_cin_i[grant_idx];
                        id_q          <= grant_idx;
                        rr_q          <= rr_next;
                        add_first_q   <= 1'b1;
                        add_request_q <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q       <= lat;
                    add_first_q <= 1'b0;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (cnt_q == CntW'(1)) begin
                        sum_q         <= add_sum_i;
                        cout_q        <= add_cout_i;
                        rsp_valid_q   <= 1'b1;
                        add_request_q <= 1'b0;
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
            endcase
        end
    end

    assign add_a_o       = add_a_q;
    assign add_b_o       = add_b_q;
    assign add_cin_o     = add_cin_q;
    assign add_first_o   = add_first_q;
    assign add_request_o = add_request_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_id_o      = id_q;
    assign rsp_sum_o     = sum_q;
    assign rsp_cout_o    = cout_q;

endmodule

// File: doc/dyn_adder_scheduler.md
Name: dyn_adder_scheduler

Overview:
- Round-robin scheduler that shares one 16-bit dynamic (variable-latency) adder among NUM_REQ requesters.
- Accepts one operation at a time and drives operands plus the F (first) pulse and request line to the adder.
- Predicts the carry-settle latency from the propagate pattern, waits exactly that many cycles, captures sum/Cout and returns a tagged response.
- Sits between the requesting datapath units and the adder_16 instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 16, operand width (fixed at 16; pair taps defined below).
- MAX_LAT, 4, worst-case settle cycles, used by the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active high.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B.
- req_cin  in  NUM_REQ  carry-in per requester.
- add_a, add_b  out  WIDTH  operands to adder.
- add_cin  out  1  carry-in to adder.
- add_first  out  1  F pulse to adder.
- add_request  out  1  release request to adder.
- add_sum  in  WIDTH  adder sum output.
- add_cout  in  1  adder carry-out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  clog2(NUM_REQ)  index of the originating requester.
- rsp_sum  out  WIDTH  captured sum.
- rsp_cout  out  1  captured carry-out.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active high.
- Reset values: state=IDLE; rr_ptr=0; all outputs 0 (add_*, rsp_*, req_ready).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first asserted req_valid searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that cycle.
  - At the edge, latch operands and id g, set rr_ptr=(g+1) mod NUM_REQ, and go to ISSUE.
  - No valid request: stay in IDLE; rr_ptr unchanged.
- ISSUE (1 cycle):
  - add_first=1 and add_request=1; add_a/add_b/add_cin hold the latched operands.
  - Compute P=a^b and L = 1 + (P[3]&P[4]) + (P[7]&P[8]) + (P[11]&P[12]), giving L in 1..4.
  - Load cnt=L and go to WAIT.
- WAIT:
  - add_first=0, add_request=1; operands held; cnt decrements each cycle.
  - In the cycle with cnt==1, capture add_sum/add_cout into rsp_sum/rsp_cout at the edge and go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_sum and rsp_cout are stable.
  - add_request=0; operands held.
  - On rsp_valid&rsp_ready: rsp_valid drops at the edge and state goes to IDLE.
  - rsp_ready low: hold indefinitely.
- Latency: rsp_valid rises L+1 edges after the accept edge; minimum accept-to-accept spacing is L+3 cycles.
- Only one operation is in flight; req_ready is 0 in every state except IDLE.
- A requester dropping req_valid while not granted has no effect; its data is not sampled.
- rst asserted in any state aborts the operation:
  - No response is produced, rsp_valid=0, rr_ptr=0 at the next edge.
  - The adder's pending result is discarded.
- A NUM_REQ that is not a power of two wraps correctly, e.g. 3 → 2 → 0.

Optional Feature:
- Macro: DYN_ADD_WORST_CASE_EN.
- Defined: L is forced to MAX_LAT for every operation, ignoring P; all other timing is unchanged. This is the safe mode for comparing against the ripple-carry bound.
- Undefined: L is computed from the propagate pairs as above.

Test Plan:
- Req0: A=0x0001, B=0x0001, cin=0 → L=1; rsp_valid 2 edges after accept; rsp_sum=0x0002, rsp_cout=0, rsp_id=0.
- Req1: A=0xFFFF, B=0x0001, cin=0 → P=0xFFFE, L=4; rsp_valid 5 edges after accept; rsp_sum=0x0000, rsp_cout=1. With DYN_ADD_WORST_CASE_EN, the 0x0001+0x0001 case also takes 5 edges.
- Req2: A=0x0018, B=0x0000 → L=2; rsp_sum=0x0018 after 3 edges; add_first high for exactly one cycle.
- req_valid=0b0101 held with rr_ptr=0 → grants in order 0, 2, 0, 2; rsp_id sequence 0, 2, 0, 2; requester 1 is never granted.
- rsp_ready held low for 10 cycles in RESP → rsp_valid and data stable throughout; req_ready stays 0; completes on the first cycle rsp_ready=1.
- rst pulsed during WAIT of an L=4 operation → no rsp_valid; next request from requester 0 is granted first; all outputs are 0 the cycle after reset.
